// File: rtl/anc_sequencer.sv
// Per-sample scheduler for the noise-cancelling datapath: buffer advance, settle,
// LMS update, FIR, then a registered speaker sample. Also flags overruns and stalled engines.
module anc_sequencer #(
    parameter int WIDTH          = 16,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1500
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sample_pulse_in,
    input  logic                    nc_on_in,
    output logic                    sampler_ready_out,
    output logic                    lms_start_out,
    input  logic                    lms_done_in,
    output logic                    fir_start_out,
    input  logic                    fir_done_in,
    input  logic signed [WIDTH-1:0] fir_sample_in,
    output logic signed [WIDTH-1:0] speaker_out,
    output logic                    speaker_valid_out,
    output logic                    busy_out,
    output logic [7:0]              overrun_count_out,
    output logic                    timeout_out,
    output logic [2:0]              state_out
);

    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW > 4) ? TW_RAW : 4;
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_LMS_RUN = 3'd3,
        ST_FIR_RUN = 3'd4,
        ST_OUTPUT  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            run_nc_q, run_nc_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timeout_hit;

    logic                    sampler_ready_q, sampler_ready_d;
    logic                    lms_start_q, lms_start_d;
    logic                    fir_start_q, fir_start_d;
    logic signed [WIDTH-1:0] speaker_q, speaker_d;
    logic                    speaker_valid_q, speaker_valid_d;
    logic                    busy_q, busy_d;
    logic [7:0]              overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            run_nc_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            run_nc_q <= run_nc_d;
            timer_q  <= timer_d;
        end
    end

    // Next state; the shared timer restarts from zero on every state change
    always_comb begin
        state_d     = state_q;
        run_nc_d    = run_nc_q;
        timer_d     = '0;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_pulse_in) begin
                    state_d  = ST_CAPTURE;
                    run_nc_d = nc_on_in;
                end
            end
            ST_CAPTURE: begin
                state_d = run_nc_q ? ST_SETTLE : ST_OUTPUT;
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_LMS_RUN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LMS_RUN: begin
                if (lms_done_in) begin
                    state_d = ST_FIR_RUN;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_FIR_RUN: begin
                if (fir_done_in) begin
                    state_d = ST_OUTPUT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (sample_pulse_in) begin
                    state_d  = ST_CAPTURE;
                    run_nc_d = nc_on_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so they line up with state_out
    always_comb begin
        sampler_ready_d = (state_d == ST_CAPTURE);
        lms_start_d     = (state_d == ST_LMS_RUN) && (state_q != ST_LMS_RUN);
        fir_start_d     = (state_d == ST_FIR_RUN) && (state_q != ST_FIR_RUN);
        speaker_valid_d = (state_d == ST_OUTPUT);
        busy_d          = (state_d != ST_IDLE);
        timeout_d       = timeout_q | timeout_hit;

        speaker_d = speaker_q;
        if ((state_q == ST_FIR_RUN) && fir_done_in) begin
            speaker_d = fir_sample_in;
        end else if ((state_q == ST_CAPTURE) && !run_nc_q) begin
            speaker_d = '0;
        end

        overrun_d = overrun_q;
        if (sample_pulse_in && (state_q inside {ST_CAPTURE, ST_SETTLE, ST_LMS_RUN, ST_FIR_RUN})
            && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sampler_ready_q <= 1'b0;
            lms_start_q     <= 1'b0;
            fir_start_q     <= 1'b0;
            speaker_q       <= '0;
            speaker_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 8'd0;
            timeout_q       <= 1'b0;
        end else begin
            sampler_ready_q <= sampler_ready_d;
            lms_start_q     <= lms_start_d;
            fir_start_q     <= fir_start_d;
            speaker_q       <= speaker_d;
            speaker_valid_q <= speaker_valid_d;
            busy_q          <= busy_d;
            overrun_q       <= overrun_d;
            timeout_q       <= timeout_d;
        end
    end

    assign sampler_ready_out = sampler_ready_q;
    assign lms_start_out     = lms_start_q;
    assign fir_start_out     = fir_start_q;
    assign speaker_out       = speaker_q;
    assign speaker_valid_out = speaker_valid_q;
    assign busy_out          = busy_q;
    assign overrun_count_out = overrun_q;
    assign timeout_out       = timeout_q;
    assign state_out         = state_q;

endmodule

// File: tb/tb_anc_sequencer.sv
// Randomized bench for anc_sequencer: each frame's event cycles are derived arithmetically
// from the pulse cycle and engine delays, then compared cycle by cycle against the outputs.
module tb_anc_sequencer;

    localparam int W       = 16;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 1500;

    logic                clk = 1'b0;
    logic                rst_in;
    logic                sample_pulse_in;
    logic                nc_on_in;
    logic                sampler_ready_out;
    logic                lms_start_out;
    logic                lms_done_in;
    logic                fir_start_out;
    logic                fir_done_in;
    logic signed [W-1:0] fir_sample_in;
    logic signed [W-1:0] speaker_out;
    logic                speaker_valid_out;
    logic                busy_out;
    logic [7:0]          overrun_count_out;
    logic                timeout_out;
    logic [2:0]          state_out;

    int                  checks = 0;
    int                  errors = 0;
    int                  cyc = 0;
    logic signed [W-1:0] exp_speaker = '0;
    int                  exp_ovr = 0;
    bit                  exp_to = 1'b0;

    anc_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_in            (clk),
        .rst_in            (rst_in),
        .sample_pulse_in   (sample_pulse_in),
        .nc_on_in          (nc_on_in),
        .sampler_ready_out (sampler_ready_out),
        .lms_start_out     (lms_start_out),
        .lms_done_in       (lms_done_in),
        .fir_start_out     (fir_start_out),
        .fir_done_in       (fir_done_in),
        .fir_sample_in     (fir_sample_in),
        .speaker_out       (speaker_out),
        .speaker_valid_out (speaker_valid_out),
        .busy_out          (busy_out),
        .overrun_count_out (overrun_count_out),
        .timeout_out       (timeout_out),
        .state_out         (state_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Frame starting with a pulse in the current cycle. df < 0 withholds fir_done;
    // abort_off >= 0 pulls reset low abort_off cycles after fir_start (together with fir_done).
    // ovr_mode: 0 none, 1 random, 2 every busy cycle, 3 three pulses just after lms_start.
    task automatic run_frame(input bit nc, input int dl, input int df,
                             input logic signed [W-1:0] val, input int ovr_mode,
                             input bit noise, input int abort_off, input string tag);
        int s, L, F, last, rst_c;
        bit timed_out, aborted, pulse;
        logic [2:0] exp_state;
        logic [5:0] exp_flags, got_flags;
        s         = cyc;
        aborted   = nc && (abort_off >= 0);
        timed_out = nc && !aborted && (df < 0);
        L         = s + 2 + SETTLE;
        F         = L + dl + 1;
        rst_c     = F + abort_off;
        if (!nc)            last = s + 2;
        else if (aborted)   last = rst_c + 1;
        else if (timed_out) last = F + TIMEOUT;
        else                last = F + df + 1;

        sample_pulse_in = 1'b1;
        nc_on_in        = nc;
        lms_done_in     = 1'b0;
        fir_done_in     = 1'b0;
        rst_in          = 1'b1;
        fir_sample_in   = W'($urandom);

        for (int c = s + 1; c <= last; c++) begin
            step();
            if (aborted && c == last) begin
                exp_state   = 3'd0;
                exp_speaker = '0;
                exp_ovr     = 0;
                exp_to      = 1'b0;
            end else if (c == last) begin
                exp_state = timed_out ? 3'd0 : 3'd5;
                if (timed_out) exp_to = 1'b1;
                else exp_speaker = nc ? val : '0;
            end else if (c == s + 1) exp_state = 3'd1;
            else if (c < L)          exp_state = 3'd2;
            else if (c < F)          exp_state = 3'd3;
            else                     exp_state = 3'd4;

            exp_flags = {c == s + 1, nc && c == L, nc && c == F,
                         c == last && !timed_out && !aborted, exp_state != 3'd0, exp_to};
            got_flags = {sampler_ready_out, lms_start_out, fir_start_out,
                         speaker_valid_out, busy_out, timeout_out};

            checks++;
            if (state_out !== exp_state) begin
                errors++;
                $display("FAIL %s state cycle %0d: got %0d expected %0d", tag, c - s, state_out, exp_state);
            end
            checks++;
            if (got_flags !== exp_flags) begin
                errors++;
                $display("FAIL %s flags{rdy,lms,fir,vld,busy,to} cycle %0d: got %b expected %b",
                         tag, c - s, got_flags, exp_flags);
            end
            checks++;
            if (speaker_out !== exp_speaker) begin
                errors++;
                $display("FAIL %s speaker cycle %0d: got %h expected %h", tag, c - s, speaker_out, exp_speaker);
            end
            checks++;
            if (overrun_count_out !== 8'(exp_ovr)) begin
                errors++;
                $display("FAIL %s overrun cycle %0d: got %0d expected %0d", tag, c - s, overrun_count_out, exp_ovr);
            end

            if (c < last) begin
                pulse = 1'b0;
                if (!(aborted && c == rst_c)) begin
                    case (ovr_mode)
                        1: pulse = ($urandom_range(0, 3) == 0);
                        2: pulse = 1'b1;
                        3: pulse = (c > L) && (c <= L + 3);
                        default: pulse = 1'b0;
                    endcase
                end
                sample_pulse_in = pulse;
                if (pulse) exp_ovr = (exp_ovr >= 255) ? 255 : exp_ovr + 1;
                nc_on_in      = noise ? 1'($urandom_range(0, 1)) : nc;
                lms_done_in   = (nc && c == L + dl) ||
                                (noise && exp_state != 3'd3 && $urandom_range(0, 3) == 0);
                fir_done_in   = (nc && !timed_out && c == F + df) ||
                                (noise && exp_state != 3'd4 && $urandom_range(0, 3) == 0);
                fir_sample_in = (nc && c == F + df) ? val : W'($urandom);
                rst_in        = !(aborted && c == rst_c);
            end else begin
                sample_pulse_in = 1'b0;
                lms_done_in     = 1'b0;
                fir_done_in     = 1'b0;
                rst_in          = 1'b1;
            end
        end
        $display("frame %s: nc=%0d dl=%0d df=%0d len=%0d speaker=%h overrun=%0d timeout=%0d",
                 tag, nc, dl, df, last - s, speaker_out, overrun_count_out, timeout_out);
    endtask

    task automatic idle_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            sample_pulse_in = 1'b0;
            nc_on_in        = 1'($urandom_range(0, 1));
            lms_done_in     = noise && ($urandom_range(0, 1) == 0);
            fir_done_in     = noise && ($urandom_range(0, 1) == 0);
            fir_sample_in   = W'($urandom);
            step();
            checks++;
            if ({state_out, sampler_ready_out, lms_start_out, fir_start_out, speaker_valid_out, busy_out}
                !== 8'd0) begin
                errors++;
                $display("FAIL idle activity: got state=%0d rdy=%b lms=%b fir=%b vld=%b busy=%b expected all 0",
                         state_out, sampler_ready_out, lms_start_out, fir_start_out,
                         speaker_valid_out, busy_out);
            end
            checks++;
            if ({speaker_out, overrun_count_out, timeout_out} !== {exp_speaker, 8'(exp_ovr), exp_to}) begin
                errors++;
                $display("FAIL idle hold: got spk=%h ovr=%0d to=%b expected spk=%h ovr=%0d to=%b",
                         speaker_out, overrun_count_out, timeout_out, exp_speaker, exp_ovr, exp_to);
            end
        end
        lms_done_in = 1'b0;
        fir_done_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; sample_pulse_in = 1'b0; nc_on_in = 1'b1;
        lms_done_in = 1'b0; fir_done_in = 1'b0; fir_sample_in = '0;
        step();
        step();
        sample_pulse_in = 1'b1;
        step();
        sample_pulse_in = 1'b0;
        checks++;
        if ({state_out, sampler_ready_out, lms_start_out, fir_start_out, speaker_valid_out, busy_out,
             timeout_out, overrun_count_out, speaker_out} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got state=%0d rdy=%b lms=%b fir=%b vld=%b busy=%b to=%b ovr=%0d spk=%h expected all 0",
                     state_out, sampler_ready_out, lms_start_out, fir_start_out, speaker_valid_out,
                     busy_out, timeout_out, overrun_count_out, speaker_out);
        end
        $display("reset: state=%0d busy=%b", state_out, busy_out);
        rst_in = 1'b1;
        exp_speaker = '0; exp_ovr = 0; exp_to = 1'b0;
    endtask

    task automatic test_nc_off();
        run_frame(1'b0, 0, 0, '0, 0, 1'b0, -1, "nc_off");
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_nominal();
        run_frame(1'b1, 5, 3, 16'sh1234, 0, 1'b0, -1, "nominal");
        idle_cycles(2, 1'b0);
        run_frame(1'b0, 0, 0, '0, 0, 1'b0, -1, "nc_off_after_value");
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_overrun();
        run_frame(1'b1, 6, 2, 16'sh0BEE, 3, 1'b0, -1, "overrun3");
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(1'b1, 1, 1, 16'sh7001, 0, 1'b0, -1, "b2b_a");
        run_frame(1'b0, 0, 0, '0, 0, 1'b0, -1, "b2b_b");
        run_frame(1'b1, 2, 0, -16'sh0123, 0, 1'b0, -1, "b2b_c");
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_early_done();
        run_frame(1'b1, 0, 0, 16'sh5A5A, 0, 1'b0, -1, "early_done");
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_frame(1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 12)),
                      int'($urandom_range(0, 12)), W'($urandom), 1, 1'b1, -1, "random");
            if ($urandom_range(0, 2) != 0) idle_cycles(int'($urandom_range(1, 3)), 1'b1);
        end
    endtask

    task automatic test_timeout();
        run_frame(1'b1, 2, -1, 16'sh4321, 0, 1'b0, -1, "fir_timeout");
        idle_cycles(2, 1'b1);
        run_frame(1'b1, 3, 4, 16'sh0777, 1, 1'b1, -1, "after_timeout");
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_saturation();
        run_frame(1'b1, 320, 2, -16'sh2000, 2, 1'b0, -1, "saturate");
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        run_frame(1'b1, 3, 1, 16'sh6666, 1, 1'b0, 1, "reset_mid_fir");
        idle_cycles(6, 1'b0);
        run_frame(1'b1, 4, 2, 16'sh0101, 0, 1'b0, -1, "after_reset");
        idle_cycles(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nc_off();
        test_nominal();
        test_overrun();
        test_back_to_back();
        test_early_done();
        test_random();
        test_timeout();
        test_saturation();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/anc_sequencer.md
Name: anc_sequencer

Overview:
- Per-sample scheduler for the adaptive noise-cancelling datapath (sample buffer -> error calculator -> LMS weight update -> 64-tap FIR).
- On each I2S new-sample pulse it advances the buffer, waits for the error to settle, runs the LMS update, then runs the FIR.
- It then registers the FIR output as the speaker sample for the volume/PWM path.
- It also detects sample overruns and stalled engines, replacing the ad-hoc chaining of done/ready pulses.

Parameters:
- WIDTH, 16, speaker/FIR sample width (signed).
- SETTLE_CYCLES, 2, cycles between buffer advance and LMS start (error calculator pipeline); legal range 1..15.
- TIMEOUT_CYCLES, 1500, maximum cycles allowed per engine run (LMS or FIR). 64 kHz frame at 100 MHz gives 1562 cycles.

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  synchronous, active-low reset
- sample_pulse_in  input  1  one-cycle pulse from i2s_receiver when a new sample is available
- nc_on_in  input  1  noise cancelling enable
- sampler_ready_out  output  1  one-cycle pulse advancing the sample buffer
- lms_start_out  output  1  one-cycle LMS start pulse
- lms_done_in  input  1  LMS completion pulse
- fir_start_out  output  1  one-cycle FIR start pulse
- fir_done_in  input  1  FIR completion pulse
- fir_sample_in  input  WIDTH  signed FIR result, valid with fir_done_in
- speaker_out  output  WIDTH  signed registered speaker sample
- speaker_valid_out  output  1  one-cycle pulse when speaker_out updates
- busy_out  output  1  high in any state except IDLE
- overrun_count_out  output  8  dropped-pulse counter, saturating
- timeout_out  output  1  sticky engine-timeout flag
- state_out  output  3  current state encoding (debug/ILA)

Behaviour:
- All outputs are registered.
- Reset (rst_in low at a clock edge) is synchronous and active-low. On reset:
  - state goes to IDLE;
  - all pulses are 0, speaker_out = 0, overrun_count_out = 0, timeout_out = 0;
  - timers clear.
- Reset mid-operation aborts the run. No start pulses are issued afterwards.
- States and encodings: IDLE=0, CAPTURE=1, SETTLE=2, LMS_RUN=3, FIR_RUN=4, OUTPUT=5.
- IDLE:
  - sample_pulse_in -> CAPTURE; nc_on_in is latched as run_nc.
- CAPTURE:
  - lasts 1 cycle; sampler_ready_out = 1.
  - If run_nc, next state is SETTLE. Otherwise next state is OUTPUT with 0 as the speaker value.
- SETTLE:
  - lasts exactly SETTLE_CYCLES cycles, then LMS_RUN.
- LMS_RUN:
  - lms_start_out = 1 in the first cycle only; the timer resets on entry.
  - lms_done_in is accepted in any LMS_RUN cycle, including the first. Accepting it moves to FIR_RUN.
- FIR_RUN:
  - fir_start_out = 1 in the first cycle only; the timer resets on entry.
  - When fir_done_in is high, fir_sample_in is captured and the state moves to OUTPUT.
- OUTPUT:
  - lasts 1 cycle; speaker_out updates (captured FIR value, or 0 when the frame ran with nc off); speaker_valid_out = 1.
  - A sample_pulse_in during OUTPUT is accepted: next state is CAPTURE and nc_on_in is latched. Otherwise next state is IDLE.
- Timeout:
  - If the timer reaches TIMEOUT_CYCLES in LMS_RUN or FIR_RUN, timeout_out sets (sticky until reset) and the state goes to IDLE.
  - No speaker_valid_out pulse is issued and speaker_out holds its previous value.
  - A done arriving in the same cycle as the timeout wins; no timeout is flagged.
- Overrun:
  - sample_pulse_in in CAPTURE, SETTLE, LMS_RUN or FIR_RUN is dropped, not queued.
  - overrun_count_out increments by 1 and saturates at 255.
- Done pulses received outside their own run state are ignored.
- nc_on_in changes mid-frame have no effect until the next accepted pulse.
- Latency with nc on: pulse at edge 0 gives:
  - sampler_ready_out in cycle 1;
  - lms_start_out in cycle 2+SETTLE_CYCLES;
  - fir_start_out in the cycle after lms_done_in;
  - speaker_valid_out in the cycle after fir_done_in.

Test Plan:
- Reset and nc off:
  - Hold rst_in low 3 cycles: all outputs 0, state_out=0.
  - Then one pulse with nc_on_in=0: sampler_ready_out in cycle 1, speaker_valid_out in cycle 2 with speaker_out=0, no lms/fir starts.
- Nominal frame:
  - Setup: nc_on_in=1, SETTLE_CYCLES=2; pulse at cycle 0; lms_done_in 5 cycles after lms_start_out; fir_done_in 3 cycles after fir_start_out with fir_sample_in=16'sh1234.
  - Expected: sampler_ready cycle 1, lms_start cycle 4, fir_start cycle 10, speaker_valid cycle 14 with speaker_out=16'sh1234.
- Overrun:
  - Three extra pulses during LMS_RUN -> overrun_count_out=3, frame completes normally.
  - 300 dropped pulses -> overrun_count_out=255.
- Back-to-back frames:
  - A pulse in the OUTPUT cycle -> CAPTURE next cycle, overrun_count_out unchanged.
- Timeout:
  - Withhold fir_done_in -> TIMEOUT_CYCLES after fir_start_out: timeout_out=1, state IDLE, speaker_out keeps its previous value, no valid pulse.
  - Next frame runs normally and timeout_out stays 1.
- Reset mid-run and early done:
  - Assert rst_in low during FIR_RUN -> IDLE next cycle, no fir_done capture, speaker_out=0.
  - lms_done_in coincident with lms_start_out -> FIR_RUN the following cycle.
